// File: rtl/sincos_cordic_seq.sv
// Sequential CORDIC sine/cosine: one request in flight, ITER+2 cycle latency (2 on range error).
// start is ignored while busy; it is accepted in the done cycle, so back-to-back requests are allowed.
module sincos_cordic_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 28,
  parameter int ITER  = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] angle_in,
  output logic             busy,
  output logic             done,
  output logic             range_err,
  output logic [WIDTH-1:0] sine_out,
  output logic [WIDTH-1:0] cosine_out
);

  localparam int IW = WIDTH + 2;
  localparam int SH = 28 - FRAC;

  function automatic logic signed [IW-1:0] kconst(input logic [31:0] q28);
    kconst = IW'($signed(q28) >>> SH);
  endfunction

  // atan(2^-i) in Q4.28, rounded to nearest
  function automatic logic [31:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_rom = 32'h0C90FDAA;
      5'd1:    atan_rom = 32'h076B19C1;
      5'd2:    atan_rom = 32'h03EB6EBF;
      5'd3:    atan_rom = 32'h01FD5BA9;
      5'd4:    atan_rom = 32'h00FFAADE;
      5'd5:    atan_rom = 32'h007FF557;
      5'd6:    atan_rom = 32'h003FFEAB;
      5'd7:    atan_rom = 32'h001FFFD5;
      5'd8:    atan_rom = 32'h000FFFFB;
      5'd9:    atan_rom = 32'h0007FFFF;
      5'd10:   atan_rom = 32'h00040000;
      5'd29,
      5'd30,
      5'd31:   atan_rom = 32'h00000000;
      default: atan_rom = 32'h10000000 >> idx;
    endcase
  endfunction

  localparam logic signed [IW-1:0] PI_2   = kconst(32'h1921FB54);
  localparam logic signed [IW-1:0] PI     = kconst(32'h3243F6A9);
  localparam logic signed [IW-1:0] PI3_2  = kconst(32'h4B65F1FD);
  localparam logic signed [IW-1:0] TWO_PI = kconst(32'h6487ED51);
  localparam logic [63:0]          X0_W   = (64'h09B74EDA + ((64'd1 << SH) >> 1)) >> SH;
  localparam logic signed [IW-1:0] X0     = $signed(IW'(X0_W));
  localparam logic signed [IW-1:0] LIM    = IW'(longint'(1) << FRAC);

  function automatic logic [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    if (v > LIM)       sat = WIDTH'(LIM);
    else if (v < -LIM) sat = WIDTH'(-LIM);
    else               sat = WIDTH'(v);
  endfunction

  typedef enum logic [1:0] {IDLE, PREP, ROT, POST} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        ang_q, ang_d;
  logic signed [IW-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
  logic [4:0]              i_q, i_d;
  logic                    flip_q, flip_d, err_q, err_d;
  logic                    done_q, done_d, rerr_q, rerr_d;
  logic [WIDTH-1:0]        sin_q, sin_d, cos_q, cos_d;

  logic signed [IW-1:0]    theta, atan_v, x_sh, y_sh, x_post, y_post;
  logic                    range_bad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ang_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      flip_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rerr_q  <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
    end else begin
      state_q <= state_d;
      ang_q   <= ang_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      flip_q  <= flip_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rerr_q  <= rerr_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
    end
  end

  assign theta     = IW'($signed(ang_q));
  assign range_bad = (theta < 0) || (theta >= TWO_PI);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PREP;
      PREP:    state_d = range_bad ? POST : ROT;
      ROT:     if (i_q == 5'(ITER - 1)) state_d = POST;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ang_d  = ang_q;
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    i_d    = i_q;
    flip_d = flip_q;
    err_d  = err_q;
    done_d = 1'b0;
    rerr_d = rerr_q;
    sin_d  = sin_q;
    cos_d  = cos_q;
    atan_v = kconst(atan_rom(i_q));
    x_sh   = x_q >>> i_q;
    y_sh   = y_q >>> i_q;
    x_post = flip_q ? -x_q : x_q;
    y_post = flip_q ? -y_q : y_q;
    case (state_q)
      IDLE: if (start) ang_d = angle_in;
      PREP: begin
        err_d = range_bad;
        i_d   = '0;
        x_d   = X0;
        y_d   = '0;
        // fold into [-pi/2, pi/2]; the middle half-turn is rotated by pi and negated afterwards
        if (theta <= PI_2) begin
          z_d    = theta;
          flip_d = 1'b0;
        end else if (theta < PI3_2) begin
          z_d    = theta - PI;
          flip_d = 1'b1;
        end else begin
          z_d    = theta - TWO_PI;
          flip_d = 1'b0;
        end
      end
      ROT: begin
        if (!z_q[IW-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_v;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_v;
        end
        i_d = i_q + 5'd1;
      end
      default: begin
        done_d = 1'b1;
        rerr_d = err_q;
        sin_d  = err_q ? '0 : sat(y_post);
        cos_d  = err_q ? '0 : sat(x_post);
      end
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    done       = done_q;
    range_err  = rerr_q;
    sine_out   = sin_q;
    cosine_out = cos_q;
  end

endmodule

// File: tb/tb_sincos_cordic_seq.sv
// Bench for sincos_cordic_seq: default 32-bit instance for directed cases, 16-bit instance for a sweep.
module tb_sincos_cordic_seq;

  localparam int AW = 32, AF = 28, AI = 24;
  localparam int BW = 16, BF = 12, BI = 12;
  localparam longint A_TWO_PI = 64'h6487ED51;
  localparam longint B_TWO_PI = 64'h6487;

  typedef struct {
    longint s;
    longint c;
    bit     err;
    longint tol;
    longint t0;
    longint lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start_a, start_b;
  logic [AW-1:0] angle_a, sine_a, cos_a;
  logic [BW-1:0] angle_b, sine_b, cos_b;
  logic busy_a, done_a, rerr_a, busy_b, done_b, rerr_b;

  longint cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sincos_cordic_seq #(.WIDTH(AW), .FRAC(AF), .ITER(AI)) dut_a (
    .clock(clk), .reset(reset), .start(start_a), .angle_in(angle_a),
    .busy(busy_a), .done(done_a), .range_err(rerr_a), .sine_out(sine_a), .cosine_out(cos_a));

  sincos_cordic_seq #(.WIDTH(BW), .FRAC(BF), .ITER(BI)) dut_b (
    .clock(clk), .reset(reset), .start(start_b), .angle_in(angle_b),
    .busy(busy_b), .done(done_b), .range_err(rerr_b), .sine_out(sine_b), .cosine_out(cos_b));

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
    n_vec++;
    if (labs(obs - exp) > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
    end
  endtask

  function automatic exp_t model(input longint ang, input int frac, input int iter,
                                 input longint two_pi, input longint t0);
    exp_t e;
    real r, sc;
    sc    = 2.0 ** frac;
    r     = real'(ang) / sc;
    e.err = (ang < 0) || (ang >= two_pi);
    e.t0  = t0;
    if (e.err) begin
      e.s = 0; e.c = 0; e.tol = 0; e.lat = 2;
    end else begin
      e.s   = longint'($floor($sin(r) * sc + 0.5));
      e.c   = longint'($floor($cos(r) * sc + 0.5));
      e.tol = (longint'(1) << (frac - iter + 3)) + 4;
      e.lat = iter + 2;
    end
    return e;
  endfunction

  // called on a falling edge; the request is taken on the next rising edge
  task automatic run_a(input longint ang);
    int g = 0;
    while (busy_a && g < 1000) begin @(negedge clk); g++; end
    start_a = 1'b1;
    angle_a = AW'(ang);
    qa.push_back(model(ang, AF, AI, A_TWO_PI, cyc + 1));
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic run_b(input longint ang);
    int g = 0;
    while (busy_b && g < 1000) begin @(negedge clk); g++; end
    start_b = 1'b1;
    angle_b = BW'(ang);
    qb.push_back(model(ang, BF, BI, B_TWO_PI, cyc + 1));
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_done_a();
    int g = 0;
    while (!done_a && g < 200) begin @(negedge clk); g++; end
    if (!done_a) chk("a_done_timeout", 0, 1, 0);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    longint s, c;
    if (done_a) begin
      chk("a_pending", longint'(qa.size() != 0), 1, 0);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        s = longint'($signed(sine_a));
        c = longint'($signed(cos_a));
        chk("a_range_err", longint'(rerr_a), longint'(e.err), 0);
        chk("a_sin", s, e.s, e.tol);
        chk("a_cos", c, e.c, e.tol);
        chk("a_latency", cyc - e.t0, e.lat, 0);
        chk("a_sat", longint'(labs(s) > (1 << AF) || labs(c) > (1 << AF)), 0, 0);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (done_b) begin
      chk("b_pending", longint'(qb.size() != 0), 1, 0);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_range_err", longint'(rerr_b), longint'(e.err), 0);
        chk("b_sin", longint'($signed(sine_b)), e.s, e.tol);
        chk("b_cos", longint'($signed(cos_b)), e.c, e.tol);
        chk("b_latency", cyc - e.t0, e.lat, 0);
      end
    end
  end

  initial begin
    int cnt, g;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    angle_a = '0;
    angle_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_a, 0, 0);
    chk("rst_done", done_a, 0, 0);
    chk("rst_rerr", rerr_a, 0, 0);
    chk("rst_sin", sine_a, 0, 0);
    chk("rst_cos", cos_a, 0, 0);
    reset = 1'b0;
    @(negedge clk);

    // zero angle, with busy length measured
    run_a(0);
    cnt = 0;
    g = 0;
    while (!done_a && g < 200) begin
      if (busy_a) cnt++;
      @(negedge clk);
      g++;
    end
    chk("a_busy_cycles", cnt, AI + 2, 0);
    chk("a_busy_at_done", busy_a, 0, 0);

    // quadrant boundaries, just below 2pi, range errors, then a valid angle clearing range_err
    run_a(64'h1921FB54);  wait_done_a();
    run_a(64'h3243F6A9);  wait_done_a();
    run_a(64'h4B65F1FD);  wait_done_a();
    run_a(64'h6487ED50);  wait_done_a();
    run_a(64'h6487ED51);  wait_done_a();
    run_a(-64'sh10000000); wait_done_a();
    run_a(64'h10000000);  wait_done_a();
    run_a(64'h5A000000);  wait_done_a();

    // start while busy and angle change after capture are both ignored
    run_a(64'h08000000);
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    angle_a = 32'h20000000;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a();

    // a start in the done cycle is accepted immediately
    start_a = 1'b1;
    angle_a = 32'h04000000;
    qa.push_back(model(64'h04000000, AF, AI, A_TWO_PI, cyc + 1));
    @(negedge clk);
    start_a = 1'b0;
    chk("a_backtoback_busy", busy_a, 1, 0);
    wait_done_a();

    // asynchronous reset mid-rotation discards the request
    run_a(64'h08000000);
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy_a, 0, 0);
    chk("arst_done", done_a, 0, 0);
    chk("arst_sin", sine_a, 0, 0);
    chk("arst_cos", cos_a, 0, 0);
    qa.delete();
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (AI + 6) begin
      @(negedge clk);
      if (done_a) cnt++;
    end
    chk("arst_no_done", cnt, 0, 0);
    run_a(64'h10000000);
    wait_done_a();

    // 16-bit sweep over [0, 2pi)
    for (int k = 0; k < 256; k++) run_b((longint'(k) * B_TWO_PI) / 256);
    g = 0;
    while ((qa.size() != 0 || qb.size() != 0) && g < 200) begin @(negedge clk); g++; end
    chk("drain_a", qa.size(), 0, 0);
    chk("drain_b", qb.size(), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sincos_cordic_seq.md
Name: sincos_cordic_seq

Overview:
- Sequential, parametrised CORDIC sine/cosine engine; successor to the combinational SinCosCalculator used by the Cyclone Cruiser trajectory and heading math.
- Takes a fixed-point angle in [0, 2π) with a start/busy/done handshake and returns signed fixed-point sin and cos after a fixed, known latency.
- Has width, fraction and iteration count as parameters, plus range checking.
- Sits between the heading/angle datapath and the motion-control blocks; one request in flight at a time.

Parameters:
- WIDTH, 32, total bits of angle_in, sine_out and cosine_out (two's complement); legal 16..32.
- FRAC, 28, fraction bits of all three signals; legal WIDTH-4 >= FRAC >= 12.
- ITER, 24, CORDIC micro-rotations; legal 8..FRAC.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only when busy=0.
- angle_in  in  WIDTH  angle in radians, signed Q(WIDTH-FRAC).FRAC; captured on the accepted start edge.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse; results valid from this edge.
- range_err  out  1  last accepted angle was < 0 or >= 2π.
- sine_out  out  WIDTH  sin(angle), signed Q.FRAC.
- cosine_out  out  WIDTH  cos(angle), signed Q.FRAC.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. busy=0, done=0, range_err=0, sine_out=0, cosine_out=0. Any in-flight computation is discarded and produces no done pulse.
- States and transitions:
  - IDLE: on start=1, capture angle_in and go to PREP. Otherwise stay.
  - PREP (1 cycle): range check and quadrant reduction.
  - ROT: ITER cycles, iteration counter i = 0..ITER-1.
  - POST (1 cycle): sign correction, saturation and output register load, then back to IDLE.
- Latency:
  - Start accepted at edge t0. busy=1 from t0 through the edge before t0+ITER+2.
  - At edge t0+ITER+2: done=1 for exactly one cycle, outputs updated, busy=0.
- Range error: angle < 0 or angle >= TWO_PI.
  - PREP returns to IDLE instead of ROT.
  - At edge t0+2: done=1, range_err=1, sine_out=cosine_out=0.
- range_err updates only when done rises; otherwise holds until the next done.
- Constants PI_2, PI, PI3_2 and TWO_PI are round(c·2^28), right-shifted arithmetically by (28-FRAC). PI_2 = 0x1921FB54 and TWO_PI = 0x6487ED51 at FRAC=28.
- Quadrant reduction (θ = captured angle):
  - θ <= PI_2: z0 = θ, flip = 0.
  - θ < PI3_2: z0 = θ - PI, flip = 1.
  - Otherwise: z0 = θ - TWO_PI, flip = 0.
- Rotation datapath:
  - x0 = round(0.6072529350·2^FRAC), y0 = 0.
  - Step i: d = sign(z) (z >= 0 → +1). Then x -= d·(y>>>i), y += d·(x>>>i), z -= d·atan(2^-i).
  - atan values come from an internal ROM of 32 Q4.28 entries, shifted like the other constants.
  - Internal x, y, z are WIDTH+2 bits wide; shifts are arithmetic.
- POST:
  - flip=1 negates x and y.
  - Saturate to [-2^FRAC, +2^FRAC].
  - Drive sine_out = y and cosine_out = x.
- Outputs hold their values until the next done.
- start while busy=1 is ignored, with no queueing.
- start is accepted in the same cycle done=1, because busy is already 0. This gives back-to-back operation at an ITER+2 period.
- angle_in changes after the capture edge have no effect.
- Accuracy: |error| <= 2^-(ITER-3), plus 4 LSB, versus real sin/cos.

Test Plan:
- Defaults; reset, then angle_in=0, start pulse → done exactly 26 cycles later, range_err=0, sine_out≈0x00000000, cosine_out≈0x10000000 within tolerance. busy high for 26 cycles.
- Angles PI_2 (0x1921FB54), PI (0x3243F6A9) and PI3_2 (0x4B65F1FD):
  - PI_2 → sin≈0x10000000, cos≈0.
  - PI → sin≈0, cos≈0xF0000000.
  - PI3_2 → sin≈0xF0000000, cos≈0.
  - No value may exceed ±0x10000000.
- 0x6487ED51 (2π) and 0xF0000000 (-1.0) → done at t0+2, range_err=1, outputs 0. A following valid angle 0x10000000 (1.0 rad) clears range_err, with sin≈0x0D76AA47 and cos≈0x08A51407.
- Start with angle 0.5 rad; pulse start with a different angle on cycle 5 of busy → ignored, result matches 0.5 rad. A new start asserted in the done cycle is accepted (busy=1 next cycle).
- Assert reset asynchronously mid-ROT (between clock edges) → all outputs 0 immediately, no done pulse. A fresh request afterward completes normally.
- Sweep 256 uniformly spaced angles over [0, 2π) with WIDTH=16, FRAC=12, ITER=12. Every result is within tolerance of $sin/$cos, and latency is 14 cycles.
